// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Turns core-side req/gnt/rvalid accesses into APB transfers: one SETUP cycle
// with psel=1/penable=0, then ACCESS cycles with psel=1/penable=1 until pready.
// Out-of-window addresses and partial-word writes are answered locally with
// err_o=1 and never reach the bus. A stalled slave is aborted after
// TIMEOUT_CYCLES ACCESS cycles.
//
// Handshake: gnt_o is combinational and equals req_i only in IDLE. A granted
// request is captured on the same rising edge. Exactly one rvalid_o pulse
// answers each grant. No new grant is given before the cycle after rvalid_o.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   req_i/gnt_o                core request / accept
//   we_i, addr_i, wdata_i, be_i  core access attributes
//   rvalid_o, rdata_o, err_o   core response (one-cycle pulse; data and flag hold)
//   paddr, pwdata, pwrite, psel, penable  APB master outputs
//   prdata, pready, pslverr    APB slave response
//   state_dbg                  current FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP)
module apb_master_bridge #(
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter int                        APB_DATA_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] WIN_START      = 32'h1A10_0000,
  parameter logic [APB_ADDR_WIDTH-1:0] WIN_END        = 32'h1A13_0000,
  parameter int                        TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic                        we_i,
  input  logic [APB_ADDR_WIDTH-1:0]   addr_i,
  input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
  input  logic [APB_DATA_WIDTH/8-1:0] be_i,
  output logic                        rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr,
  output logic [APB_DATA_WIDTH-1:0]   pwdata,
  output logic                        pwrite,
  output logic                        psel,
  output logic                        penable,
  input  logic [APB_DATA_WIDTH-1:0]   prdata,
  input  logic                        pready,
  input  logic                        pslverr,
  output logic [1:0]                  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // The counter only has to reach TIMEOUT_CYCLES-1: the abort is taken in the
  // ACCESS cycle that would have made it TIMEOUT_CYCLES.
  localparam int                        CW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]             CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [APB_DATA_WIDTH/8-1:0] BE_ALL = '1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          in_win;
  logic          partial_wr;

  assign in_win     = (addr_i >= WIN_START) && (addr_i <= WIN_END);
  assign partial_wr = we_i && (be_i != BE_ALL);
  assign gnt_o      = (state == IDLE) && req_i;
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      pwrite   <= 1'b0;
      psel     <= 1'b0;
      penable  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            paddr  <= addr_i;
            pwrite <= we_i;
            pwdata <= wdata_i;
            if (!in_win || partial_wr) begin
              // Answered locally; the APB bus stays idle.
              rvalid_o <= 1'b1;
              err_o    <= 1'b1;
              rdata_o  <= '0;
              state    <= RESP;
            end else begin
              psel    <= 1'b1;
              penable <= 1'b0;
              cnt     <= '0;
              state   <= SETUP;
            end
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready is checked first so a completion in the last allowed
          // cycle is a normal response, not a timeout.
          if (pready) begin
            psel     <= 1'b0;
            penable  <= 1'b0;
            rvalid_o <= 1'b1;
            err_o    <= pslverr;
            rdata_o  <= pwrite ? '0 : prdata;
            state    <= RESP;
          end else if (cnt == CNT_LAST) begin
            psel     <= 1'b0;
            penable  <= 1'b0;
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
            rdata_o  <= '0;
            state    <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          rvalid_o <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
